// File: rtl/bg_elim_sequencer_pkg.sv
// Shared definitions for the background-elimination frame sequencer:
// state encodings, err_code values and the timeout-activity helper.
package bg_elim_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_WAIT_WR = 3'd3,
      ST_SETTLE  = 3'd4,
      ST_RUN     = 3'd5,
      ST_ERROR   = 3'd6
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_SHORT   = 2'b10;

   // States in which lack of camera/writer progress is supervised
   function automatic logic tmo_active(state_t s);
      return (s == ST_ARM) || (s == ST_CAPTURE) ||
             (s == ST_WAIT_WR) || (s == ST_SETTLE);
   endfunction

endpackage

// File: rtl/bg_elim_sequencer_timeout.sv
// Progress watchdog for the sequencer.
// Ports: clk, resetn (sync, active-low), restart (state entry), kick
// (progress event), en (supervised state), expire (comb, limit reached).
module seq_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
   input  logic clk,
   input  logic resetn,
   input  logic restart,
   input  logic kick,
   input  logic en,
   output logic expire
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (restart || kick || !en) begin
         cnt <= '0;
      end else if (cnt != LAST) begin
         cnt <= cnt + TW'(1);
      end
   end

   // A progress event on the final cycle still counts as progress,
   // so it suppresses the expiry rather than racing it.
   assign expire = en && !kick && (cnt == LAST);

endmodule

// File: rtl/bg_elim_sequencer.sv
// Frame-level controller: captures a reference frame, waits for commit
// and settle, then enables the stream aligner; supervises the stream.
// Ports: clk, resetn, start/stop/recapture commands, sof_new/eol_new/
// wr_done events; cap_en, align_en, busy, err, err_code, frame_cnt.
module bg_elim_sequencer
   import bg_elim_sequencer_pkg::*;
#(
   parameter int unsigned FRAME_LINES    = 480,
   parameter int unsigned SETTLE_FRAMES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4000000,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             stop,
   input  logic             recapture,
   input  logic             sof_new,
   input  logic             eol_new,
   input  logic             wr_done,
   output logic             cap_en,
   output logic             align_en,
   output logic             busy,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam int LW = $clog2(FRAME_LINES + 1);
   // +2 keeps the width non-zero when SETTLE_FRAMES is 0
   localparam int SW = $clog2(SETTLE_FRAMES + 2);
   localparam logic [LW-1:0] LINE_LAST   = LW'(FRAME_LINES);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_FRAMES);

   state_t            state_q, state_d;
   logic [LW-1:0]     line_q, line_d, line_nxt;
   logic [SW-1:0]     settle_q, settle_d, settle_nxt;
   logic [CNT_W-1:0]  frame_d;
   logic [1:0]        code_d;
   logic              tmo_expire;

   seq_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_tmo (
      .clk    (clk),
      .resetn (resetn),
      .restart(state_d != state_q),
      .kick   (sof_new || eol_new || wr_done),
      .en     (tmo_active(state_q)),
      .expire (tmo_expire)
   );

   always_comb begin
      state_d    = state_q;
      line_d     = line_q;
      settle_d   = settle_q;
      frame_d    = frame_cnt;
      code_d     = err_code;
      line_nxt   = line_q + LW'(1);
      settle_nxt = settle_q + SW'(1);

      if (stop && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
      end else if (tmo_expire) begin
         state_d = ST_ERROR;
         code_d  = ERR_TIMEOUT;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) state_d = ST_ARM;
            end
            ST_ARM: begin
               line_d = '0;
               if (sof_new) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
               // The closing eol is counted before a same-cycle sof
               if (eol_new) line_d = line_nxt;
               if (eol_new && line_nxt == LINE_LAST) begin
                  state_d = ST_WAIT_WR;
               end else if (sof_new) begin
                  state_d = ST_ERROR;
                  code_d  = ERR_SHORT;
               end
            end
            ST_WAIT_WR: begin
               settle_d = '0;
               if (wr_done) begin
                  state_d = (SETTLE_FRAMES == 0) ? ST_RUN : ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (sof_new) begin
                  settle_d = settle_nxt;
                  if (settle_nxt == SETTLE_LAST) state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (sof_new && frame_cnt != '1) begin
                  frame_d = frame_cnt + CNT_W'(1);
               end
               if (recapture) state_d = ST_ARM;
            end
            ST_ERROR: begin
               if (start) state_d = ST_ARM;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      if (state_d != ST_ERROR) code_d = ERR_NONE;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         line_q    <= '0;
         settle_q  <= '0;
         frame_cnt <= '0;
         err_code  <= ERR_NONE;
         cap_en    <= 1'b0;
         align_en  <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_q   <= state_d;
         line_q    <= line_d;
         settle_q  <= settle_d;
         frame_cnt <= frame_d;
         err_code  <= code_d;
         cap_en    <= (state_d == ST_ARM) || (state_d == ST_CAPTURE);
         align_en  <= (state_d == ST_RUN);
         busy      <= (state_d != ST_IDLE) && (state_d != ST_ERROR);
         err       <= (state_d == ST_ERROR);
      end
   end

endmodule

// File: tb/tb_bg_elim_sequencer.sv
// Directed bench for bg_elim_sequencer (4 lines, 2 settle, 100 timeout,
// 3-bit frame counter so saturation is reachable).
module tb_bg_elim_sequencer;

   logic       clk = 1'b0;
   logic       resetn, start, stop, recapture;
   logic       sof_new, eol_new, wr_done;
   logic       cap_en, align_en, busy, err;
   logic [1:0] err_code;
   logic [2:0] frame_cnt;
   logic [5:0] outs;

   int nvec = 0;
   int nerr = 0;

   bg_elim_sequencer #(
      .FRAME_LINES   (4),
      .SETTLE_FRAMES (2),
      .TIMEOUT_CYCLES(100),
      .CNT_W         (3)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .start    (start),
      .stop     (stop),
      .recapture(recapture),
      .sof_new  (sof_new),
      .eol_new  (eol_new),
      .wr_done  (wr_done),
      .cap_en   (cap_en),
      .align_en (align_en),
      .busy     (busy),
      .err      (err),
      .err_code (err_code),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // {cap_en, align_en, busy, err, err_code}
   assign outs = {cap_en, align_en, busy, err, err_code};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic p_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   task automatic p_sof();
      sof_new = 1'b1; step(); sof_new = 1'b0;
   endtask

   task automatic p_eol();
      eol_new = 1'b1; step(); eol_new = 1'b0;
   endtask

   task automatic p_wr();
      wr_done = 1'b1; step(); wr_done = 1'b0;
   endtask

   task automatic p_recap();
      recapture = 1'b1; step(); recapture = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0; start = 1'b0; stop = 1'b0; recapture = 1'b0;
      sof_new = 1'b0; eol_new = 1'b0; wr_done = 1'b0;
      idle(2);
      nvec++;
      if (outs !== 6'b000000) begin
         $display("FAIL reset_outs got %b want %b", outs, 6'b000000); nerr++;
      end
      nvec++;
      if (frame_cnt !== 3'd0) begin
         $display("FAIL reset_frame got %0d want 0", frame_cnt); nerr++;
      end
      resetn = 1'b1;
      stop = 1'b1; step(); stop = 1'b0;
      nvec++;
      if (outs !== 6'b000000) begin
         $display("FAIL idle_stop got %b want %b", outs, 6'b000000); nerr++;
      end
   endtask

   task automatic test_capture_run();
      p_start();
      nvec++;
      if (outs !== 6'b101000) begin
         $display("FAIL arm got %b want %b", outs, 6'b101000); nerr++;
      end
      p_sof();
      repeat (3) p_eol();
      p_wr();
      nvec++;
      if (outs !== 6'b101000) begin
         $display("FAIL capture_3 got %b want %b", outs, 6'b101000); nerr++;
      end
      p_eol();
      nvec++;
      if (outs !== 6'b001000) begin
         $display("FAIL wait_wr got %b want %b", outs, 6'b001000); nerr++;
      end
      p_wr();
      p_sof();
      nvec++;
      if (outs !== 6'b001000) begin
         $display("FAIL settle_1 got %b want %b", outs, 6'b001000); nerr++;
      end
      p_sof();
      nvec++;
      if (outs !== 6'b011000) begin
         $display("FAIL run got %b want %b", outs, 6'b011000); nerr++;
      end
   endtask

   task automatic test_frame_cnt();
      repeat (5) p_sof();
      nvec++;
      if (frame_cnt !== 3'd5) begin
         $display("FAIL frame_5 got %0d want 5", frame_cnt); nerr++;
      end
      p_recap();
      nvec++;
      if (outs !== 6'b101000) begin
         $display("FAIL recap got %b want %b", outs, 6'b101000); nerr++;
      end
      nvec++;
      if (frame_cnt !== 3'd5) begin
         $display("FAIL recap_frame got %0d want 5", frame_cnt); nerr++;
      end
   endtask

   task automatic test_short_frame();
      p_sof();
      repeat (3) p_eol();
      p_sof();
      nvec++;
      if (outs !== 6'b000110) begin
         $display("FAIL short got %b want %b", outs, 6'b000110); nerr++;
      end
      p_start();
      nvec++;
      if (outs !== 6'b101000) begin
         $display("FAIL err_start got %b want %b", outs, 6'b101000); nerr++;
      end
   endtask

   task automatic test_timeout();
      p_sof();
      repeat (4) p_eol();
      idle(99);
      nvec++;
      if (outs !== 6'b001000) begin
         $display("FAIL tmo_edge got %b want %b", outs, 6'b001000); nerr++;
      end
      step();
      nvec++;
      if (outs !== 6'b000101) begin
         $display("FAIL tmo got %b want %b", outs, 6'b000101); nerr++;
      end
      p_start();
      p_sof();
      repeat (4) p_eol();
      idle(99);
      p_wr();
      step();
      nvec++;
      if (outs !== 6'b001000) begin
         $display("FAIL wr_late got %b want %b", outs, 6'b001000); nerr++;
      end
      p_sof();
      p_sof();
      nvec++;
      if (outs !== 6'b011000) begin
         $display("FAIL run_2 got %b want %b", outs, 6'b011000); nerr++;
      end
   endtask

   task automatic test_stop_recapture();
      stop = 1'b1; recapture = 1'b1; step();
      stop = 1'b0; recapture = 1'b0;
      nvec++;
      if (outs !== 6'b000000) begin
         $display("FAIL stop_recap got %b want %b", outs, 6'b000000); nerr++;
      end
      nvec++;
      if (frame_cnt !== 3'd5) begin
         $display("FAIL stop_frame got %0d want 5", frame_cnt); nerr++;
      end
      p_start();
      p_sof();
      repeat (2) p_eol();
      p_start();
      nvec++;
      if (outs !== 6'b101000) begin
         $display("FAIL start_busy got %b want %b", outs, 6'b101000); nerr++;
      end
      repeat (2) p_eol();
      nvec++;
      if (outs !== 6'b001000) begin
         $display("FAIL no_restart got %b want %b", outs, 6'b001000); nerr++;
      end
   endtask

   task automatic test_back_to_back();
      p_wr();
      p_sof();
      p_sof();
      p_recap();
      p_sof();
      repeat (3) p_eol();
      sof_new = 1'b1; eol_new = 1'b1; step();
      sof_new = 1'b0; eol_new = 1'b0;
      nvec++;
      if (outs !== 6'b001000) begin
         $display("FAIL eol_sof got %b want %b", outs, 6'b001000); nerr++;
      end
      p_wr();
      p_sof();
      p_sof();
      repeat (4) p_sof();
      nvec++;
      if (frame_cnt !== 3'd7) begin
         $display("FAIL frame_sat got %0d want 7", frame_cnt); nerr++;
      end
      p_recap();
      p_sof();
      p_eol();
      resetn = 1'b0; step();
      nvec++;
      if (outs !== 6'b000000) begin
         $display("FAIL mid_reset got %b want %b", outs, 6'b000000); nerr++;
      end
      nvec++;
      if (frame_cnt !== 3'd0) begin
         $display("FAIL mid_reset_frame got %0d want 0", frame_cnt); nerr++;
      end
      resetn = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_capture_run();
      test_frame_cnt();
      test_short_frame();
      test_timeout();
      test_stop_recapture();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
